// File: rtl/mini_alu_pkg.sv
// Shared definitions for the mini ALU processor: opcodes, instruction field
// layout, register-file reset contents and opcode decode.
package mini_alu_pkg;

    localparam int WORD_W    = 32;
    localparam int REG_COUNT = 32;
    localparam int OPC_W     = 6;
    localparam int REG_IDX_W = 5;

    // Instruction layout: [5:0] opcode, [10:6] rs1, [15:11] rs2, [20:16] rd.
    localparam int OPC_LSB      = 0;
    localparam int RS1_LSB      = 6;
    localparam int RS2_LSB      = 11;
    localparam int RD_LSB       = 16;
    localparam int INSTR_W      = 32;
    localparam int INSTR_USED_W = RD_LSB + REG_IDX_W;

    typedef logic [OPC_W-1:0]     opcode_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [WORD_W-1:0]    word_t;

    localparam opcode_t OP_MIN = 6'h01;
    localparam opcode_t OP_ADD = 6'h04;
    localparam opcode_t OP_AND = 6'h05;
    localparam opcode_t OP_NOT = 6'h06;
    localparam opcode_t OP_XOR = 6'h07;
    localparam opcode_t OP_ABS = 6'h08;
    localparam opcode_t OP_OR  = 6'h09;
    localparam opcode_t OP_MAX = 6'h0A;
    localparam opcode_t OP_NEG = 6'h0B;
    localparam opcode_t OP_AVG = 6'h0D;
    localparam opcode_t OP_SUB = 6'h0E;

    localparam word_t RESET_TABLE [REG_COUNT] = '{
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_3BE2,
        32'h0000_257A, 32'h0000_399A, 32'h0000_0CD8, 32'h0000_0000,
        32'h0000_0000, 32'h0000_1330, 32'h0000_0000, 32'h0000_0000,
        32'h0000_31B6, 32'h0000_00B0, 32'h0000_0000, 32'h0000_20CA,
        32'h0000_3524, 32'h0000_0000, 32'h0000_0000, 32'h0000_27CE,
        32'h0000_221E, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_1686, 32'h0000_0000, 32'h0000_0000
    };

    function automatic logic is_valid_opcode(input opcode_t opc);
        case (opc)
            OP_ADD, OP_SUB, OP_ABS, OP_NEG, OP_MAX, OP_MIN,
            OP_AVG, OP_NOT, OP_OR, OP_AND, OP_XOR: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mini_alu_processor_if.sv
// Instruction/result bundle between the sequencer (master) and the processor (slave).
interface mini_alu_processor_if #(
    parameter int DATA_W = 32
);
    // No back-pressure: a new instruction is consumed every cycle, and op_valid
    // marks that the current instruction is supported and will write back.
    logic [31:0]       instruction;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_valid;

    modport master (
        output instruction,
        input  result,
        input  op_a,
        input  op_b,
        input  op_valid
    );

    modport slave (
        input  instruction,
        output result,
        output op_a,
        output op_b,
        output op_valid
    );
endinterface

// File: rtl/mini_alu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// synchronous reset loading the constant reset table.
module mini_alu_regfile
    import mini_alu_pkg::*;
#(
    parameter int DATA_W   = WORD_W,
    parameter int NUM_REGS = REG_COUNT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] rs1_addr,
    input  logic [REG_IDX_W-1:0] rs2_addr,
    input  logic [REG_IDX_W-1:0] rd_addr,
    input  logic                 wr_en,
    input  logic [DATA_W-1:0]    wr_data,
    output logic [DATA_W-1:0]    rs1_data,
    output logic [DATA_W-1:0]    rs2_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Reset wins over a same-edge write; R0 is an ordinary writable register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(RESET_TABLE[i]);
            end
        end else if (wr_en) begin
            regs[rd_addr] <= wr_data;
        end
    end

    // Reads see the pre-edge contents; there is no write bypass.
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

endmodule

// File: rtl/mini_alu_processor.sv
// Single-cycle datapath: decode, read two registers, compute a signed ALU
// result combinationally and write it back on the rising edge.
module mini_alu_processor
    import mini_alu_pkg::*;
#(
    parameter int DATA_W   = WORD_W,
    parameter int NUM_REGS = REG_COUNT
) (
    input  logic                 clk,
    input  logic                 reset,
    mini_alu_processor_if.slave  bus
);

    opcode_t                   opcode;
    reg_idx_t                  rs1_idx;
    reg_idx_t                  rs2_idx;
    reg_idx_t                  rd_idx;
    logic                      valid;
    logic signed [DATA_W-1:0]  a;
    logic signed [DATA_W-1:0]  b;
    logic signed [DATA_W-1:0]  sum;
    logic signed [DATA_W-1:0]  avg_adj;
    logic signed [DATA_W-1:0]  alu_out;
    logic                      unused_hi;

    assign opcode  = bus.instruction[OPC_LSB +: OPC_W];
    assign rs1_idx = bus.instruction[RS1_LSB +: REG_IDX_W];
    assign rs2_idx = bus.instruction[RS2_LSB +: REG_IDX_W];
    assign rd_idx  = bus.instruction[RD_LSB  +: REG_IDX_W];
    assign unused_hi = ^bus.instruction[INSTR_W-1:INSTR_USED_W];

    assign valid = is_valid_opcode(opcode);

    mini_alu_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1_idx),
        .rs2_addr (rs2_idx),
        .rd_addr  (rd_idx),
        .wr_en    (valid),
        .wr_data  (alu_out),
        .rs1_data (a),
        .rs2_data (b)
    );

    // AVG truncates toward zero: bias negative sums by one before the
    // arithmetic shift so that e.g. -3 halves to -1 rather than -2.
    always_comb begin
        sum     = a + b;
        avg_adj = sum + DATA_W'(sum[DATA_W-1]);
        alu_out = '0;
        case (opcode)
            OP_ADD:  alu_out = sum;
            OP_SUB:  alu_out = a - b;
            OP_ABS:  alu_out = a[DATA_W-1] ? -a : a;
            OP_NEG:  alu_out = -a;
            OP_MAX:  alu_out = (a > b) ? a : b;
            OP_MIN:  alu_out = (a < b) ? a : b;
            OP_AVG:  alu_out = avg_adj >>> 1;
            OP_NOT:  alu_out = ~a;
            OP_OR:   alu_out = a | b;
            OP_AND:  alu_out = a & b;
            OP_XOR:  alu_out = a ^ b;
            default: alu_out = '0;
        endcase
    end

    assign bus.op_a     = a;
    assign bus.op_b     = b;
    assign bus.result   = alu_out;
    assign bus.op_valid = valid;

endmodule

// File: tb/tb_mini_alu_processor.sv
// Bench for mini_alu_processor: directed vector table, hand-built boundary
// sequences and randomized instructions against an arithmetic reference model.
module tb_mini_alu_processor;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mini_alu_processor_if #(.DATA_W(32)) bus ();

    mini_alu_processor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] exp_reset [32];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_res;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [$];

    // ---------------- helpers ----------------
    function automatic logic [31:0] enc(input logic [5:0] op, input int rs1,
                                        input int rs2, input int rd);
        logic [4:0] r1, r2, d;
        r1 = 5'(rs1);
        r2 = 5'(rs2);
        d  = 5'(rd);
        return {11'b0, d, r2, r1, op};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference model: plain signed integer arithmetic on the spec's rules.
    function automatic logic [32:0] ref_alu(input logic [5:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa, sb, s;
        logic [31:0] r;
        sa = a;
        sb = b;
        case (op)
            6'h04: r = sa + sb;
            6'h0E: r = sa - sb;
            6'h08: r = (sa < 0) ? -sa : sa;
            6'h0B: r = -sa;
            6'h0A: r = (sa > sb) ? a : b;
            6'h01: r = (sa < sb) ? a : b;
            6'h0D: begin s = sa + sb; r = s / 2; end
            6'h06: r = ~a;
            6'h09: r = a | b;
            6'h05: r = a & b;
            6'h07: r = a ^ b;
            default: return 33'h0;
        endcase
        return {1'b1, r};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = exp_reset[i];
    endtask

    task automatic model_apply(input logic [31:0] instr);
        logic [32:0] vr;
        vr = ref_alu(instr[5:0], m_regs[instr[10:6]], m_regs[instr[15:11]]);
        if (vr[32]) m_regs[instr[20:16]] = vr[31:0];
    endtask

    task automatic sample(input logic [31:0] instr, input logic rst);
        bus.instruction = instr;
        reset = rst;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) model_reset();
        else model_apply(bus.instruction);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [32:0] vr;
        logic [31:0] ea, eb;
        ea = m_regs[bus.instruction[10:6]];
        eb = m_regs[bus.instruction[15:11]];
        vr = ref_alu(bus.instruction[5:0], ea, eb);
        check32({tag, " op_a"}, bus.op_a, ea);
        check32({tag, " op_b"}, bus.op_b, eb);
        check32({tag, " result"}, bus.result, vr[31:0]);
        check32({tag, " op_valid"}, {31'b0, bus.op_valid}, {31'b0, vr[32]});
    endtask

    task automatic add_vec(input logic [31:0] instr, input logic [31:0] ea,
                           input logic [31:0] eb, input logic [31:0] er, input logic ev);
        vec_t v;
        v.instr = instr; v.exp_a = ea; v.exp_b = eb; v.exp_res = er; v.exp_valid = ev;
        vecs.push_back(v);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [5:0] valid_ops [11];
        logic [5:0] op;
        logic       rst;
        logic [31:0] instr;

        valid_ops = '{6'h04, 6'h0E, 6'h08, 6'h0B, 6'h0A, 6'h01, 6'h0D, 6'h06, 6'h09, 6'h05, 6'h07};

        for (int i = 0; i < 32; i++) exp_reset[i] = 32'h0;
        exp_reset[3]  = 32'h3BE2; exp_reset[4]  = 32'h257A; exp_reset[5]  = 32'h399A;
        exp_reset[6]  = 32'h0CD8; exp_reset[9]  = 32'h1330; exp_reset[12] = 32'h31B6;
        exp_reset[13] = 32'h00B0; exp_reset[15] = 32'h20CA; exp_reset[16] = 32'h3524;
        exp_reset[19] = 32'h27CE; exp_reset[20] = 32'h221E; exp_reset[29] = 32'h1686;

        // Directed sequence; each row depends on the writes of the rows before it.
        add_vec(enc(6'h04, 5, 12, 1),  32'h399A, 32'h31B6, 32'h6B50, 1);
        add_vec(enc(6'h0E, 9, 1, 2),   32'h1330, 32'h6B50, 32'hFFFFA7E0, 1);
        add_vec(enc(6'h08, 2, 0, 0),   32'hFFFFA7E0, 32'h0, 32'h5820, 1);
        add_vec(enc(6'h0D, 3, 13, 7),  32'h3BE2, 32'h00B0, 32'h1E49, 1);
        add_vec(enc(6'h01, 15, 12, 31), 32'h20CA, 32'h31B6, 32'h20CA, 1);
        add_vec(enc(6'h0D, 7, 31, 8),  32'h1E49, 32'h20CA, 32'h1F89, 1);
        add_vec(enc(6'h06, 5, 0, 22),  32'h399A, 32'h5820, 32'hFFFFC665, 1);
        add_vec(enc(6'h09, 29, 4, 3),  32'h1686, 32'h257A, 32'h37FE, 1);
        add_vec(enc(6'h05, 1, 15, 23), 32'h6B50, 32'h20CA, 32'h2040, 1);
        add_vec(enc(6'h07, 19, 20, 24), 32'h27CE, 32'h221E, 32'h05D0, 1);
        add_vec(enc(6'h0A, 16, 5, 25), 32'h3524, 32'h399A, 32'h399A, 1);
        add_vec(enc(6'h0B, 5, 0, 26),  32'h399A, 32'h5820, 32'hFFFFC666, 1);
        for (int i = 0; i < 3; i++)
            add_vec(enc(6'h17, 3, 3, 3), 32'h37FE, 32'h37FE, 32'h0, 0);
        add_vec(enc(6'h3F, 1, 2, 1),   32'h6B50, 32'hFFFFA7E0, 32'h0, 0);
        add_vec(enc(6'h0E, 10, 10, 10), 32'h0, 32'h0, 32'h0, 1);
        add_vec(enc(6'h06, 10, 0, 11), 32'h0, 32'h5820, 32'hFFFFFFFF, 1);
        add_vec(enc(6'h04, 11, 11, 17), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
        add_vec(enc(6'h04, 17, 11, 17), 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 1);
        add_vec(enc(6'h0D, 17, 10, 18), 32'hFFFFFFFD, 32'h0, 32'hFFFFFFFF, 1);
        add_vec(enc(6'h07, 24, 25, 27) | 32'hFFE0_0000, 32'h05D0, 32'h399A, 32'h3C4A, 1);

        // Reset
        reset = 1'b1;
        bus.instruction = '0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;

        // Reset contents, read through both ports with an unsupported opcode.
        for (int i = 0; i < 32; i++) begin
            sample(enc(6'h00, i, 31 - i, 0), 1'b0);
            check32($sformatf("reset R%0d", i), bus.op_a, exp_reset[i]);
            check32($sformatf("reset R%0d b", 31 - i), bus.op_b, exp_reset[31 - i]);
            check32("reset op_valid", {31'b0, bus.op_valid}, 32'h0);
            check32("reset result", bus.result, 32'h0);
            advance();
        end

        foreach (vecs[k]) begin
            sample(vecs[k].instr, 1'b0);
            check32($sformatf("vec%0d op_a", k), bus.op_a, vecs[k].exp_a);
            check32($sformatf("vec%0d op_b", k), bus.op_b, vecs[k].exp_b);
            check32($sformatf("vec%0d result", k), bus.result, vecs[k].exp_res);
            check32($sformatf("vec%0d op_valid", k), {31'b0, bus.op_valid}, {31'b0, vecs[k].exp_valid});
            advance();
        end

        // Held ADD with rs1=rs2=rd: written once per edge, so two edges quadruple it.
        sample(enc(6'h04, 1, 1, 1), 1'b0);
        check32("hold1 result", bus.result, 32'hD6A0);
        advance();
        sample(enc(6'h04, 1, 1, 1), 1'b0);
        check32("hold2 op_a", bus.op_a, 32'hD6A0);
        check32("hold2 result", bus.result, 32'h1AD40);
        advance();
        sample(enc(6'h00, 1, 1, 1), 1'b0);
        check32("hold quadrupled", bus.op_a, 32'h1AD40);
        advance();

        // Build 0x80000000 by doubling 1 thirty-one times.
        sample(enc(6'h0B, 11, 0, 21), 1'b0);
        check32("neg -1", bus.result, 32'h1);
        advance();
        for (int i = 0; i < 31; i++) begin
            sample(enc(6'h04, 21, 21, 21), 1'b0);
            check_model("double");
            advance();
        end
        sample(enc(6'h08, 21, 0, 28), 1'b0);
        check32("abs min op_a", bus.op_a, 32'h80000000);
        check32("abs min result", bus.result, 32'h80000000);
        advance();
        sample(enc(6'h06, 21, 0, 30), 1'b0);
        check32("not min", bus.result, 32'h7FFFFFFF);
        advance();
        sample(enc(6'h0B, 11, 0, 14), 1'b0);
        advance();
        sample(enc(6'h04, 30, 14, 27), 1'b0);
        check32("add wrap op_b", bus.op_b, 32'h1);
        check32("add wrap result", bus.result, 32'h80000000);
        advance();
        sample(enc(6'h0A, 30, 27, 0), 1'b0);
        check32("max signed", bus.result, 32'h7FFFFFFF);
        advance();
        sample(enc(6'h01, 30, 27, 0), 1'b0);
        check32("min signed", bus.result, 32'h80000000);
        advance();
        sample(enc(6'h0E, 27, 14, 0), 1'b0);
        check32("sub wrap", bus.result, 32'h7FFFFFFF);
        advance();

        // Reset during a valid instruction: table reloads, write suppressed.
        sample(enc(6'h04, 3, 3, 3), 1'b1);
        advance();
        sample(enc(6'h00, 3, 1, 0), 1'b0);
        check32("midreset R3", bus.op_a, 32'h3BE2);
        check32("midreset R1", bus.op_b, 32'h0);
        advance();

        // Randomized instructions against the reference model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) != 0) op = valid_ops[$urandom_range(0, 10)];
            else op = 6'($urandom_range(0, 63));
            instr = enc(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            instr[31:21] = 11'($urandom);
            sample(instr, rst);
            if (!rst) check_model("rand");
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
